uart_rx_oversample: RTL and testbench

//  UART receiver consuming the 16x-oversample tick from the baud generator. Synchronises rx,

---
 rtl/uart_rx_oversample.sv | 119 +++++++++++
 tb/tb_uart_rx_oversample.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// UART receiver driven by a 16x (OVERSAMPLE) baud tick: 2-flop rx synchroniser,
// mid-bit sampling FSM, and a one-word holding register with ready/framing/overrun flags.
module uart_rx_oversample #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 read_strobe,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   complete;

  assign complete = enable && baud_tick && (state == STOP) && (tick_cnt == FULL_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_data       <= '0;
      rx_ready      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;

      // A read coinciding with completion consumes the old word, so no overrun.
      if (complete) begin
        rx_data       <= shift;
        rx_ready      <= 1'b1;
        framing_error <= ~rx_s;
        overrun       <= read_strobe ? 1'b0 : (overrun | rx_ready);
      end else if (read_strobe && rx_ready) begin
        rx_ready      <= 1'b0;
        framing_error <= 1'b0;
        overrun       <= 1'b0;
      end

      if (!enable) begin
        state    <= IDLE;
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= rx_s ? IDLE : BREAK;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: stimulus pushes expected words, a monitor
// pops and compares whenever a new word is presented on rx_data/rx_ready.
module tb_uart_rx_oversample;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       baud_tick;
  logic       rx;
  logic       read_strobe;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];

  uart_rx_oversample #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .read_strobe   (read_strobe),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick every 4 clocks, updated on the falling edge.
  initial begin
    int phase;
    phase = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 4;
      baud_tick = (phase == 0);
    end
  end

  // Monitor: a word is presented when rx_ready rises, or when the word/flags change while ready.
  initial begin
    logic       prev_rdy;
    logic [9:0] prev_word;
    exp_t       got;
    exp_t       want;
    prev_rdy  = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge clk);
      got = '{d: rx_data, fe: framing_error, ov: overrun};
      if (!reset && rx_ready && (!prev_rdy || got != prev_word)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_word: got data=%h fe=%b ov=%b, want no word", got.d, got.fe, got.ov);
        end else begin
          want = exp_q.pop_front();
          if (got != want) begin
            n_bad++;
            $display("FAIL word: got data=%h fe=%b ov=%b, want data=%h fe=%b ov=%b",
                     got.d, got.fe, got.ov, want.d, want.fe, want.ov);
          end
        end
      end
      prev_rdy  = rx_ready;
      prev_word = got;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic align_tick();
    do nclk(1); while (!baud_tick);
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic ov);
    exp_q.push_back('{d: d, fe: fe, ov: ov});
  endtask

  // Start bit set just before a tick edge T0; stop sample lands on the edge T0+612.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit strobe_at_done);
    align_tick();
    rx = 1'b0;
    nclk(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      nclk(64);
    end
    rx = stop;
    if (strobe_at_done) begin
      nclk(36);
      read_strobe = 1'b1;
      nclk(1);
      read_strobe = 1'b0;
      nclk(27);
    end else begin
      nclk(64);
    end
  endtask

  task automatic send_partial_ff(input int nbits);
    align_tick();
    rx = 1'b0;
    nclk(64);
    rx = 1'b1;
    nclk(64 * nbits + 10);
  endtask

  task automatic read_word();
    read_strobe = 1'b1;
    nclk(1);
    read_strobe = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    rx          = 1'b1;
    read_strobe = 1'b0;
    nclk(4);
    reset = 1'b0;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_ready", 32'(rx_ready), 32'h0);
    check("reset_framing", 32'(framing_error), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    nclk(20);

    // 1: clean 0xA5
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_ready", 32'(rx_ready), 32'h1);
    read_word();
    check("a5_ready_cleared", 32'(rx_ready), 32'h0);

    // 2: false start (low for 6 ticks)
    align_tick();
    rx = 1'b0;
    nclk(20);
    check("false_start_busy", 32'(busy), 32'h1);
    nclk(4);
    rx = 1'b1;
    nclk(40);
    check("false_start_idle", 32'(busy), 32'h0);
    check("false_start_ready", 32'(rx_ready), 32'h0);

    // 3: 0x3C with low stop bit, line held low 3 bit times -> BREAK
    push(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    nclk(128);
    check("break_busy", 32'(busy), 32'h1);
    check("break_framing", 32'(framing_error), 32'h1);
    rx = 1'b1;
    nclk(20);
    check("break_exit", 32'(busy), 32'h0);
    read_word();
    check("break_read_ready", 32'(rx_ready), 32'h0);
    check("break_read_fe", 32'(framing_error), 32'h0);

    // 4: overrun
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("overrun_set", 32'(overrun), 32'h1);
    read_word();
    check("overrun_read_ready", 32'(rx_ready), 32'h0);
    check("overrun_read_ov", 32'(overrun), 32'h0);

    // 5: read_strobe coincides with completion of 0x77
    push(8'h66, 1'b0, 1'b0);
    push(8'h77, 1'b0, 1'b0);
    send_frame(8'h66, 1'b1, 1'b0);
    send_frame(8'h77, 1'b1, 1'b1);
    check("coincide_ready", 32'(rx_ready), 32'h1);
    check("coincide_ov", 32'(overrun), 32'h0);
    check("coincide_data", 32'(rx_data), 32'h77);
    read_word();

    // 6a: reset mid-frame
    send_partial_ff(4);
    reset = 1'b1;
    nclk(1);
    reset = 1'b0;
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_data", 32'(rx_data), 32'h00);
    push(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    read_word();

    // 6b: enable dropped mid-frame
    send_partial_ff(4);
    enable = 1'b0;
    nclk(2);
    enable = 1'b1;
    check("disable_busy", 32'(busy), 32'h0);
    check("disable_data_hold", 32'(rx_data), 32'h5A);
    push(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    read_word();
    nclk(10);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
